// File: rtl/fpu_wb_sched.sv
// Issue/writeback scheduler for the fixed-latency FP units: a latency-indexed
// reservation shift register tracks in-flight ops and stalls result-bus collisions.
module fpu_wb_sched #(
    parameter int TAG_W    = 5,
    parameter int LAT_ADD  = 1,
    parameter int LAT_MUL  = 1,
    parameter int LAT_DIV  = 3,
    parameter int LAT_SQRT = 2,
    parameter int LAT_CVT  = 1,
    parameter int MAX_LAT  = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     in_op,
    input  logic [TAG_W-1:0]               in_tag,
    input  logic                           flush,
    input  logic [31:0]                    add_res,
    input  logic [31:0]                    mul_res,
    input  logic [31:0]                    div_res,
    input  logic [31:0]                    sqrt_res,
    input  logic [31:0]                    floor_res,
    input  logic [31:0]                    ftoi_res,
    input  logic [31:0]                    itof_res,
    input  logic                           cmp_eq,
    input  logic                           cmp_lt,
    output logic                           wb_valid,
    output logic [TAG_W-1:0]               wb_tag,
    output logic [31:0]                    wb_data,
    output logic                           wb_is_int,
    output logic                           illegal,
    output logic [$clog2(MAX_LAT+1)-1:0]   outstanding
);
    localparam int LW = $clog2(MAX_LAT + 2);
    localparam int CW = $clog2(MAX_LAT + 1);

    localparam logic [2:0] SEL_ADD   = 3'd0;
    localparam logic [2:0] SEL_MUL   = 3'd1;
    localparam logic [2:0] SEL_DIV   = 3'd2;
    localparam logic [2:0] SEL_SQRT  = 3'd3;
    localparam logic [2:0] SEL_FLOOR = 3'd4;
    localparam logic [2:0] SEL_FTOI  = 3'd5;
    localparam logic [2:0] SEL_ITOF  = 3'd6;
    localparam logic [2:0] SEL_CMP   = 3'd7;

    logic [MAX_LAT:1]   valid_q, valid_d;
    logic [MAX_LAT:1]   cmp_q, cmp_d;
    logic [2:0]         sel_q [MAX_LAT:1];
    logic [2:0]         sel_d [MAX_LAT:1];
    logic [TAG_W-1:0]   tag_q [MAX_LAT:1];
    logic [TAG_W-1:0]   tag_d [MAX_LAT:1];
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               illegal_q, illegal_d;

    logic [LW-1:0]      lat;
    logic [2:0]         sel_new;
    logic               legal, cmp_new, accept;
    logic [MAX_LAT+1:1] valid_ext;

    always_comb begin
        lat     = LW'(1);
        sel_new = SEL_ADD;
        legal   = 1'b1;
        case (in_op)
            4'd0, 4'd1:       begin lat = LW'(LAT_ADD);  sel_new = SEL_ADD;  end
            4'd2:             begin lat = LW'(LAT_MUL);  sel_new = SEL_MUL;  end
            4'd3:             begin lat = LW'(LAT_DIV);  sel_new = SEL_DIV;  end
            4'd4:             begin lat = LW'(LAT_SQRT); sel_new = SEL_SQRT; end
            4'd5:             begin lat = LW'(LAT_CVT);  sel_new = SEL_FLOOR; end
            4'd6:             begin lat = LW'(LAT_CVT);  sel_new = SEL_FTOI; end
            4'd7:             begin lat = LW'(LAT_CVT);  sel_new = SEL_ITOF; end
            4'd8, 4'd9:       begin lat = LW'(1);        sel_new = SEL_CMP;  end
            default:          legal = 1'b0;
        endcase
    end

    assign cmp_new = (in_op == 4'd9) ? cmp_lt : cmp_eq;

    // Slot L+1 shifts into slot L at this edge; a zero pad makes MAX_LAT ops never stall.
    assign valid_ext = {1'b0, valid_q};
    assign in_ready  = !flush && !valid_ext[lat + LW'(1)];
    assign accept    = in_valid && in_ready;

    always_comb begin
        valid_d = '0;
        cmp_d   = '0;
        for (int i = 1; i <= MAX_LAT; i++) begin
            sel_d[i] = '0;
            tag_d[i] = '0;
        end
        for (int i = 1; i < MAX_LAT; i++) begin
            valid_d[i] = valid_q[i+1];
            cmp_d[i]   = cmp_q[i+1];
            sel_d[i]   = sel_q[i+1];
            tag_d[i]   = tag_q[i+1];
        end
        if (flush) begin
            valid_d = '0;
        end else if (accept && legal) begin
            for (int i = 1; i <= MAX_LAT; i++) begin
                if (lat == LW'(i)) begin
                    valid_d[i] = 1'b1;
                    cmp_d[i]   = cmp_new;
                    sel_d[i]   = sel_new;
                    tag_d[i]   = in_tag;
                end
            end
        end
        cnt_d = '0;
        for (int i = 1; i <= MAX_LAT; i++) begin
            cnt_d = cnt_d + CW'(valid_d[i]);
        end
        illegal_d = accept && !legal;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q   <= '0;
            cmp_q     <= '0;
            for (int i = 1; i <= MAX_LAT; i++) begin
                sel_q[i] <= '0;
                tag_q[i] <= '0;
            end
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            cmp_q     <= cmp_d;
            sel_q     <= sel_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        wb_valid  = valid_q[1];
        wb_tag    = '0;
        wb_data   = '0;
        wb_is_int = 1'b0;
        if (valid_q[1]) begin
            wb_tag    = tag_q[1];
            wb_is_int = (sel_q[1] == SEL_FTOI) || (sel_q[1] == SEL_CMP);
            case (sel_q[1])
                SEL_ADD:   wb_data = add_res;
                SEL_MUL:   wb_data = mul_res;
                SEL_DIV:   wb_data = div_res;
                SEL_SQRT:  wb_data = sqrt_res;
                SEL_FLOOR: wb_data = floor_res;
                SEL_FTOI:  wb_data = ftoi_res;
                SEL_ITOF:  wb_data = itof_res;
                default:   wb_data = {31'b0, cmp_q[1]};
            endcase
        end
    end

    assign illegal     = illegal_q;
    assign outstanding = cnt_q;
endmodule

// File: tb/tb_fpu_wb_sched.sv
// Bench for fpu_wb_sched: a vector table plus hand sequences and a random burst,
// with a due-cycle scoreboard predicting every writeback, stall and count.
module tb_fpu_wb_sched;
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_tag;
  logic        flush;
  logic [31:0] add_res, mul_res, div_res, sqrt_res, floor_res, ftoi_res, itof_res;
  logic        cmp_eq, cmp_lt;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_is_int;
  logic        illegal;
  logic [2:0]  outstanding;

  fpu_wb_sched dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_tag(in_tag), .flush(flush),
    .add_res(add_res), .mul_res(mul_res), .div_res(div_res), .sqrt_res(sqrt_res),
    .floor_res(floor_res), .ftoi_res(ftoi_res), .itof_res(itof_res),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_is_int(wb_is_int),
    .illegal(illegal), .outstanding(outstanding)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // unit outputs: a per-unit tag in the top nibble and the current cycle below
  function automatic logic [31:0] uval(int u, int c);
    return {4'(u + 1), 12'h000, 16'(c)};
  endfunction
  assign add_res   = uval(0, cyc);
  assign mul_res   = uval(1, cyc);
  assign div_res   = uval(2, cyc);
  assign sqrt_res  = uval(3, cyc);
  assign floor_res = uval(4, cyc);
  assign ftoi_res  = uval(5, cyc);
  assign itof_res  = uval(6, cyc);

  function automatic int lat_of(logic [3:0] op);
    case (op)
      4'd3:    return 3;
      4'd4:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unit_of(logic [3:0] op);
    case (op)
      4'd0, 4'd1: return 0;
      4'd2:       return 1;
      4'd3:       return 2;
      4'd4:       return 3;
      4'd5:       return 4;
      4'd6:       return 5;
      4'd7:       return 6;
      default:    return 7;
    endcase
  endfunction

  // scoreboard: {due_cycle[15:0], tag[4:0], is_int, data[31:0]}
  logic [53:0] exp_q[$];
  int          ill_at = -1;
  int          total = 0;
  int          passed = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
  endtask

  function automatic bit has_due(int c);
    foreach (exp_q[i]) if (int'(exp_q[i][53:38]) == c) return 1'b1;
    return 1'b0;
  endfunction

  // monitor: checks every cycle, then applies the edge's effect to the model
  int          m_idx, m_pend, m_lat, m_due;
  logic        m_rdy;
  logic [31:0] m_data;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      m_idx = -1;
      m_pend = 0;
      foreach (exp_q[i]) begin
        if (int'(exp_q[i][53:38]) == cyc) m_idx = i;
        if (int'(exp_q[i][53:38]) >= cyc) m_pend++;
      end
      if (m_idx >= 0) begin
        check("wb", {wb_valid, wb_tag, wb_is_int, wb_data}, {1'b1, exp_q[m_idx][37:0]});
        exp_q.delete(m_idx);
      end else begin
        check("wb_idle", {wb_valid, wb_tag, wb_is_int, wb_data}, 64'd0);
      end
      check("outstanding", 64'(outstanding), 64'(m_pend));
      check("illegal", 64'(illegal), 64'(cyc == ill_at));
      m_lat = lat_of(in_op);
      m_rdy = !flush && !(m_lat < 4 && has_due(cyc + m_lat));
      if (rstn && in_valid) check("in_ready", 64'(in_ready), 64'(m_rdy));
      if (!rstn) begin
        exp_q.delete();
        ill_at = -1;
      end else if (flush) begin
        exp_q.delete();
      end else if (in_valid && m_rdy) begin
        if (in_op >= 4'd10) begin
          ill_at = cyc + 1;
        end else begin
          m_due = cyc + m_lat;
          if (in_op >= 4'd8) m_data = {31'b0, (in_op == 4'd9) ? cmp_lt : cmp_eq};
          else               m_data = uval(unit_of(in_op), m_due);
          exp_q.push_back({16'(m_due), in_tag,
                           (in_op == 4'd6) || (in_op == 4'd8) || (in_op == 4'd9), m_data});
        end
      end
    end
  end

  // driver tasks
  task automatic drive(logic v, logic [3:0] op, logic [4:0] tag, logic eq, logic lt, logic fl);
    @(posedge clk);
    #1;
    in_valid = v;
    in_op    = op;
    in_tag   = tag;
    cmp_eq   = eq;
    cmp_lt   = lt;
    flush    = fl;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic [4:0] tag;
    logic       eq;
    logic       lt;
    logic       fl;
    logic       rdy;
  } vec_t;
  vec_t tbl[$];

  initial begin
    // v, op, tag, eq, lt, flush, expected in_ready
    tbl.push_back('{1'b1, 4'd0,  5'd1,  1'b0, 1'b0, 1'b0, 1'b1});  // pipelined fadds
    tbl.push_back('{1'b1, 4'd0,  5'd2,  1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd0,  5'd3,  1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd3,  5'd4,  1'b0, 1'b0, 1'b0, 1'b1});  // fdiv, then colliding fadd
    tbl.push_back('{1'b0, 4'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd4,  5'd6,  1'b0, 1'b0, 1'b0, 1'b1});  // fsqrt blocks next fmul
    tbl.push_back('{1'b1, 4'd2,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd2,  5'd7,  1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd8,  5'd8,  1'b1, 1'b0, 1'b0, 1'b1});  // feq true, fless false
    tbl.push_back('{1'b1, 4'd9,  5'd9,  1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd6,  5'd10, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd7,  5'd11, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd5,  5'd12, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd1,  5'd13, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd12, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1});  // undefined op
    tbl.push_back('{1'b1, 4'd3,  5'd15, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd3,  5'd16, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd4,  5'd17, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd0,  5'd18, 1'b0, 1'b0, 1'b1, 1'b0});  // flush with tag 15 on the bus
    tbl.push_back('{1'b0, 4'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0});

    rstn = 1'b0; in_valid = 1'b1; in_op = 4'd0; in_tag = 5'd1;
    flush = 1'b0; cmp_eq = 1'b0; cmp_lt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    in_valid = 1'b0;
    idle(5);

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].op, tbl[k].tag, tbl[k].eq, tbl[k].lt, tbl[k].fl);
      #1;
      if (tbl[k].v) check("ready_tbl", 64'(in_ready), 64'(tbl[k].rdy));
    end
    idle(4);

    // flush mid-flight: fdiv then flush with an op offered
    drive(1'b1, 4'd3, 5'd20, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 5'd21, 1'b0, 1'b0, 1'b1);
    #1;
    check("ready_flush", 64'(in_ready), 64'd0);
    idle(5);

    // reset mid-flight: nothing may write back afterwards
    drive(1'b1, 4'd3, 5'd22, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(5);

    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0);
    end
    idle(8);

    check("drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fpu_wb_sched.md
Name: fpu_wb_sched

Overview:
- Issue/writeback scheduler that sits between the core's FP issue stage and the free-running FP units (fadd, fmul, fdiv, fsqrt, floor, ftoi, itof, feq, fless).
- Accepts tagged operations over a valid/ready handshake and tracks in-flight operations in a latency-indexed reservation shift register.
- Stalls issue when two operations would collide on the single result bus.
- Returns one tagged writeback per cycle, selected from the unit result inputs. This lets the fixed-latency units run pipelined instead of one operation at a time.

Parameters:
- TAG_W, 5, destination tag width.
- LAT_ADD, 1, fadd/fsub latency in cycles.
- LAT_MUL, 1, fmul latency.
- LAT_DIV, 3, fdiv latency.
- LAT_SQRT, 2, fsqrt latency.
- LAT_CVT, 1, floor/ftoi/itof latency.
- MAX_LAT, 4, reservation depth. Must be >= every LAT_*. Every LAT_* must be >= 1.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, synchronous active-low reset.
- in_valid, in, 1, operation offered.
- in_ready, out, 1, operation can be accepted this cycle.
- in_op, in, 4, 0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fsqrt, 5 floor, 6 ftoi, 7 itof, 8 feq, 9 fless.
- in_tag, in, TAG_W, destination tag.
- flush, in, 1, discard all in-flight operations.
- add_res, mul_res, div_res, sqrt_res, floor_res, ftoi_res, itof_res, in, 32 each, unit outputs.
- cmp_eq, cmp_lt, in, 1 each, combinational compare of the current operands.
- wb_valid, out, 1, writeback this cycle.
- wb_tag, out, TAG_W, writeback tag.
- wb_data, out, 32, writeback value.
- wb_is_int, out, 1, wb_data is integer (ftoi, feq, fless).
- illegal, out, 1, one-cycle pulse for an accepted undefined op.
- outstanding, out, $clog2(MAX_LAT+1), number of in-flight operations.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low on rstn.
- Reset values: all reservation slots invalid, wb_valid=0, wb_tag=0, wb_data=0, wb_is_int=0, illegal=0, outstanding=0. Reset mid-operation discards everything in flight, with no writeback afterwards.
- Latency classes:
  - add (ops 0,1) = LAT_ADD; mul (2) = LAT_MUL; div (3) = LAT_DIV; sqrt (4) = LAT_SQRT; floor/ftoi/itof (5,6,7) = LAT_CVT.
  - cmp (8,9) = 1. cmp_eq/cmp_lt are sampled at the issue edge and held in the slot.
- Reservation register: slots res[1..MAX_LAT], each holding {valid, sel[2:0], tag, cmp_bit}.
  - Every clock: res[i] <= res[i+1], and res[MAX_LAT] <= invalid.
  - On accept (in_valid && in_ready) of an op with latency L: res[L] <= new entry, overriding the shifted value (guaranteed invalid by the stall rule).
- Stall rule: in_ready = !flush && !(L < MAX_LAT && res[L+1].valid), where L is the latency of in_op. An op with L = MAX_LAT never stalls.
- Writeback timing: an op accepted at edge T produces wb_valid=1 in the cycle after edge T+L-1, i.e. exactly L cycles after acceptance. wb_tag and wb_data come from res[1].
- Writeback values:
  - wb_data is combinational from res[1].sel, using the matching *_res input.
  - For cmp: wb_data = {31'b0, cmp_bit}.
  - wb_is_int = 1 for sel ftoi or cmp.
  - When res[1] is invalid: wb_valid=0, wb_data=0, wb_tag=0, wb_is_int=0.
  - Registered fields are valid from edge to edge; only the data mux is combinational.
- Ordering: results are returned in completion order, not issue order. Exactly one writeback per cycle is guaranteed by the stall rule.
- Undefined ops (10-15): in_ready follows the L=1 rule. On accept, no slot is written and illegal pulses high for one cycle after the edge.
- Flush:
  - At a clock edge with flush=1, all slots are cleared and no new entry is written.
  - in_ready=0 while flush=1.
  - A writeback visible in the same cycle as flush is still valid; flush affects state only after the edge.
- outstanding = number of valid slots. It is registered, updated with the slots, and is 0 after flush or reset.
- Simultaneous events: an accept and res[1] retiring in the same edge are both handled, so the count changes by +1-1 = 0.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with in_valid=1 → in_ready ignored, wb_valid=0, outstanding=0, no writeback for 5 cycles after release.
- Pipelined adds: fadd with tags 1,2,3 on consecutive cycles, add_res driven = tag*0x100 → wb_valid on 3 consecutive cycles starting 1 cycle after the first accept, wb_tag 1,2,3, wb_data 0x100,0x200,0x300.
- Collision stall: fdiv tag 4 at cycle 0, then fadd tag 5 offered at cycle 2 → in_ready=0 at cycle 2, fadd accepted at cycle 3. Writebacks: tag 4 at cycle 3, tag 5 at cycle 4.
- Compare: feq with cmp_eq=1, then fless with cmp_lt=0 → wb_data 0x00000001 then 0x00000000, wb_is_int=1 both times.
- Flush mid-flight: fdiv issued at cycle 0, flush=1 at cycle 1 → outstanding=0 at cycle 2, no writeback at cycle 3, in_ready=0 during cycle 1.
- Illegal op: in_op=12 accepted → illegal=1 for exactly one cycle, outstanding unchanged, no writeback.
